rat_alu_flags: RTL

//   8-bit ALU with C/Z flag registers and interrupt shadow flags. Consumes the

---
 rtl/rat_alu_pkg.sv | 31 +++
 rtl/rat_flag_reg.sv | 42 ++++
 rtl/rat_alu_flags.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rat_alu_pkg.sv
// Shared types for the RAT ALU: default width, opcode enum, multiply FSM states.
package rat_alu_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDC = 4'd1,
        OP_SUB  = 4'd2,
        OP_SUBC = 4'd3,
        OP_CMP  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_EXOR = 4'd7,
        OP_TEST = 4'd8,
        OP_LSL  = 4'd9,
        OP_LSR  = 4'd10,
        OP_ROL  = 4'd11,
        OP_ROR  = 4'd12,
        OP_ASR  = 4'd13,
        OP_MOV  = 4'd14,
        OP_MUL  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/rat_flag_reg.sv
// C/Z flag registers with interrupt shadow copy and RETI restore mux.
module rat_flag_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic c_in,
    input  logic z_in,
    input  logic c_ld,
    input  logic z_ld,
    input  logic c_set,
    input  logic c_clr,
    input  logic ld_sel,
    input  logic shad_ld,
    output logic c_flag,
    output logic z_flag
);

    logic shad_c, shad_z;
    logic c_src, z_src;

    assign c_src = ld_sel ? shad_c : c_in;
    assign z_src = ld_sel ? shad_z : z_in;

    // Shadow samples the pre-edge flags, so entry and load in one cycle both take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_flag <= 1'b0;
            z_flag <= 1'b0;
            shad_c <= 1'b0;
            shad_z <= 1'b0;
        end else begin
            if (c_clr)      c_flag <= 1'b0;
            else if (c_set) c_flag <= 1'b1;
            else if (c_ld)  c_flag <= c_src;
            if (z_ld)       z_flag <= z_src;
            if (shad_ld) begin
                shad_c <= c_flag;
                shad_z <= z_flag;
            end
        end
    end

endmodule

// File: rtl/rat_alu_flags.sv
// 8-bit RAT ALU with flag registers; ALU_MUL_EN adds a multi-cycle shift-add multiply on op 15.
module rat_alu_flags
    import rat_alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [3:0]        ALU_SEL,
    input  logic              FLG_C_LD,
    input  logic              FLG_Z_LD,
    input  logic              FLG_C_SET,
    input  logic              FLG_C_CLR,
    input  logic              FLG_LD_SEL,
    input  logic              FLG_SHAD_LD,
`ifdef ALU_MUL_EN
    input  logic              MUL_START,
    output logic              MUL_BUSY,
    output logic              MUL_DONE,
`endif
    output logic [DATA_W-1:0] RESULT,
    output logic              C_FLAG,
    output logic              Z_FLAG
);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] res;
    logic              c_out, z_out;
    logic [DATA_W:0]   cin_w;

    assign cin_w = {{DATA_W{1'b0}}, C_FLAG};

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(DATA_W) + 1;

    mul_state_e          state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] mcand, acc, acc_nxt, prod;
    logic [DATA_W-1:0]   mplier;

    assign acc_nxt  = mplier[0] ? acc + mcand : acc;
    assign MUL_BUSY = (state == RUN);
    assign MUL_DONE = (state == DONE);

    // Product register only changes at the end of a run, so op 15 reads a stable value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            prod   <= '0;
        end else begin
            case (state)
                IDLE: if (MUL_START && ALU_SEL == OP_MUL) begin
                    mcand  <= {{DATA_W{1'b0}}, A};
                    mplier <= B;
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        prod  <= acc_nxt;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`endif

    always_comb begin
        sum   = '0;
        res   = '0;
        c_out = 1'b0;
        case (alu_op_e'(ALU_SEL))
            OP_ADD:  begin sum = {1'b0, A} + {1'b0, B};         res = sum[DATA_W-1:0]; c_out = sum[DATA_W]; end
            OP_ADDC: begin sum = {1'b0, A} + {1'b0, B} + cin_w; res = sum[DATA_W-1:0]; c_out = sum[DATA_W]; end
            OP_SUB,
            OP_CMP:  begin sum = {1'b0, A} - {1'b0, B};         res = sum[DATA_W-1:0]; c_out = sum[DATA_W]; end
            OP_SUBC: begin sum = {1'b0, A} - {1'b0, B} - cin_w; res = sum[DATA_W-1:0]; c_out = sum[DATA_W]; end
            OP_AND,
            OP_TEST: res = A & B;
            OP_OR:   res = A | B;
            OP_EXOR: res = A ^ B;
            OP_LSL:  begin res = {A[DATA_W-2:0], C_FLAG};   c_out = A[DATA_W-1]; end
            OP_LSR:  begin res = {C_FLAG, A[DATA_W-1:1]};   c_out = A[0]; end
            OP_ROL:  begin res = {A[DATA_W-2:0], A[DATA_W-1]}; c_out = A[DATA_W-1]; end
            OP_ROR:  begin res = {A[0], A[DATA_W-1:1]};     c_out = A[0]; end
            OP_ASR:  begin res = {A[DATA_W-1], A[DATA_W-1:1]}; c_out = A[0]; end
            OP_MOV:  begin res = B; c_out = C_FLAG; end
`ifdef ALU_MUL_EN
            OP_MUL:  begin res = prod[DATA_W-1:0]; c_out = |prod[2*DATA_W-1:DATA_W]; end
`endif
            default: begin res = '0; c_out = 1'b0; end
        endcase
        z_out = (res == '0);
`ifdef ALU_MUL_EN
        if (ALU_SEL == OP_MUL) z_out = (prod == '0);
`endif
    end

    assign RESULT = res;

    rat_flag_reg u_flags (
        .clk     (CLK),
        .rst_n   (RST_N),
        .c_in    (c_out),
        .z_in    (z_out),
        .c_ld    (FLG_C_LD),
        .z_ld    (FLG_Z_LD),
        .c_set   (FLG_C_SET),
        .c_clr   (FLG_C_CLR),
        .ld_sel  (FLG_LD_SEL),
        .shad_ld (FLG_SHAD_LD),
        .c_flag  (C_FLAG),
        .z_flag  (Z_FLAG)
    );

endmodule
